// File: rtl/mat_mul_acc.sv
// NxN signed matrix multiply-accumulate: registered products, a DEPTH-stage adder tree and an accumulator.
// Define MAT_MUL_ACC_SAT_EN for saturating accumulation with a sticky overflow flag; otherwise it wraps.
module mat_mul_acc #(
  parameter int W_IN  = 8,
  parameter int W_OUT = 32,
  parameter int N     = 4
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   in_last,
  input  logic signed [N-1:0][N-1:0][W_IN-1:0]   matrix_1,
  input  logic signed [N-1:0][N-1:0][W_IN-1:0]   matrix_2,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [N-1:0][N-1:0][W_OUT-1:0]  result,
  output logic                                   overflow
);

  localparam int DEPTH = $clog2(N);
  localparam int L     = 1 << DEPTH;
  localparam int PW    = 2 * W_IN;
  localparam int SW    = PW + DEPTH;

  typedef enum logic [1:0] {ACCUM, DRAIN, OUTPUT} state_t;

  state_t               state_q, state_d;
  logic                 accept, out_hs, pipe_busy;
  logic [DEPTH:0]       vld_q;
  logic                 acc_vld_q;
  logic signed [SW-1:0] prod_c [N][N][L];
  logic signed [SW-1:0] lvl_q  [DEPTH+1][N][N][L];
  logic signed [W_OUT-1:0] acc_q [N][N];
  logic signed [W_OUT-1:0] acc_d [N][N];

  function automatic logic signed [PW-1:0] sx(input logic [W_IN-1:0] v);
    return {{W_IN{v[W_IN-1]}}, v};
  endfunction

  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign pipe_busy = (|vld_q) || acc_vld_q;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && in_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (!pipe_busy) state_d = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Leaves beyond N stay zero so the tree always reduces a power-of-two width.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        for (int unsigned k = 0; k < L; k++) begin
          prod_c[i][j][k] = '0;
          if (k < N) prod_c[i][j][k] = SW'(sx(matrix_1[i][k]) * sx(matrix_2[k][j]));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) lvl_q[0] <= prod_c;
    for (int unsigned d = 1; d <= DEPTH; d++) begin
      if (vld_q[d-1]) begin
        for (int unsigned i = 0; i < N; i++) begin
          for (int unsigned j = 0; j < N; j++) begin
            for (int unsigned m = 0; m < (L >> d); m++) begin
              lvl_q[d][i][j][m] <= lvl_q[d-1][i][j][2*m] + lvl_q[d-1][i][j][2*m+1];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ACCUM;
      vld_q     <= '0;
      acc_vld_q <= 1'b0;
      acc_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      vld_q[0]  <= accept;
      for (int unsigned d = 1; d <= DEPTH; d++) vld_q[d] <= vld_q[d-1];
      acc_vld_q <= vld_q[DEPTH];
      acc_q     <= acc_d;
    end
  end

`ifdef MAT_MUL_ACC_SAT_EN
  localparam logic signed [W_OUT-1:0] ACC_MAX = {1'b0, {(W_OUT-1){1'b1}}};
  localparam logic signed [W_OUT-1:0] ACC_MIN = {1'b1, {(W_OUT-1){1'b0}}};

  logic                  ovf_q, ovf_d;
  logic signed [W_OUT:0] wide_c;

  // One guard bit above W_OUT detects the clip; tree sums always fit in W_OUT.
  always_comb begin
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    wide_c = '0;
    if (out_hs) begin
      acc_d = '{default: '0};
      ovf_d = 1'b0;
    end else if (vld_q[DEPTH]) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          wide_c = (W_OUT+1)'(acc_q[i][j]) + (W_OUT+1)'(lvl_q[DEPTH][i][j][0]);
          if (wide_c[W_OUT] != wide_c[W_OUT-1]) begin
            acc_d[i][j] = wide_c[W_OUT] ? ACC_MIN : ACC_MAX;
            ovf_d       = 1'b1;
          end else begin
            acc_d[i][j] = wide_c[W_OUT-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  always_comb begin
    acc_d = acc_q;
    if (out_hs) begin
      acc_d = '{default: '0};
    end else if (vld_q[DEPTH]) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          acc_d[i][j] = acc_q[i][j] + W_OUT'(lvl_q[DEPTH][i][j][0]);
        end
      end
    end
  end

  assign overflow = 1'b0;
`endif

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        result[i][j] = acc_q[i][j];
      end
    end
  end

endmodule

// File: tb/tb_mat_mul_acc.sv
// Bench for mat_mul_acc: an N=2/W_OUT=20 and an N=3/W_OUT=32 instance checked against an arithmetic model.
// The expected accumulation follows MAT_MUL_ACC_SAT_EN the same way the design does.
module tb_mat_mul_acc;
  localparam int W_IN = 8;
  localparam int NA   = 2;
  localparam int WOA  = 20;
  localparam int NB   = 3;
  localparam int WOB  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, vld, lst, ordy;
  int   sel;
  int   ma [3][3];
  int   mb [3][3];

  logic a_in_ready, a_out_valid, a_ovf;
  logic signed [NA-1:0][NA-1:0][W_IN-1:0] a_m1, a_m2;
  logic signed [NA-1:0][NA-1:0][WOA-1:0]  a_res;
  logic b_in_ready, b_out_valid, b_ovf;
  logic signed [NB-1:0][NB-1:0][W_IN-1:0] b_m1, b_m2;
  logic signed [NB-1:0][NB-1:0][WOB-1:0]  b_res;

  always_comb begin
    for (int i = 0; i < NA; i++)
      for (int j = 0; j < NA; j++) begin
        a_m1[i][j] = ma[i][j][W_IN-1:0];
        a_m2[i][j] = mb[i][j][W_IN-1:0];
      end
    for (int i = 0; i < NB; i++)
      for (int j = 0; j < NB; j++) begin
        b_m1[i][j] = ma[i][j][W_IN-1:0];
        b_m2[i][j] = mb[i][j][W_IN-1:0];
      end
  end

  mat_mul_acc #(.W_IN(W_IN), .W_OUT(WOA), .N(NA)) u_a (
    .clk(clk), .resetn(resetn), .in_valid(vld && sel == 0), .in_ready(a_in_ready),
    .in_last(lst), .matrix_1(a_m1), .matrix_2(a_m2), .out_valid(a_out_valid),
    .out_ready(ordy && sel == 0), .result(a_res), .overflow(a_ovf));

  mat_mul_acc #(.W_IN(W_IN), .W_OUT(WOB), .N(NB)) u_b (
    .clk(clk), .resetn(resetn), .in_valid(vld && sel == 1), .in_ready(b_in_ready),
    .in_last(lst), .matrix_1(b_m1), .matrix_2(b_m2), .out_valid(b_out_valid),
    .out_ready(ordy && sel == 1), .result(b_res), .overflow(b_ovf));

  int     n_checks = 0;
  int     n_errors = 0;
  longint exp_acc [3][3];
  bit     exp_ovf;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cur_n();     return (sel == 0) ? NA  : NB;  endfunction
  function automatic int cur_w();     return (sel == 0) ? WOA : WOB; endfunction
  function automatic int cur_depth(); return (sel == 0) ? 1   : 2;   endfunction
  function automatic logic obs_ready();  return (sel == 0) ? a_in_ready  : b_in_ready;  endfunction
  function automatic logic obs_ovalid(); return (sel == 0) ? a_out_valid : b_out_valid; endfunction
  function automatic logic obs_ovf();    return (sel == 0) ? a_ovf       : b_ovf;       endfunction
  function automatic longint obs_res(input int i, input int j);
    if (sel == 0) return longint'($signed(a_res[i][j]));
    return longint'($signed(b_res[i][j]));
  endfunction

  // Reference: each beat adds the exact product matrix, then the sum is wrapped or clipped to W_OUT.
  task automatic model_beat();
    longint s, v, lim, m;
    int w;
    w   = cur_w();
    lim = longint'(1) << (w - 1);
    m   = longint'(1) << w;
    for (int i = 0; i < cur_n(); i++)
      for (int j = 0; j < cur_n(); j++) begin
        s = 0;
        for (int k = 0; k < cur_n(); k++) s += longint'(ma[i][k]) * longint'(mb[k][j]);
        v = exp_acc[i][j] + s;
`ifdef MAT_MUL_ACC_SAT_EN
        if (v > lim - 1) begin v = lim - 1; exp_ovf = 1'b1; end
        if (v < -lim)    begin v = -lim;    exp_ovf = 1'b1; end
`else
        v = v & (m - 1);
        if (v >= lim) v -= m;
`endif
        exp_acc[i][j] = v;
      end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) exp_acc[i][j] = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic fill(input int a_diag, input int a_off, input int b_val);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        ma[i][j] = (i == j) ? a_diag : a_off;
        mb[i][j] = b_val;
      end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        ma[i][j] = int'($urandom_range(255)) - 128;
        mb[i][j] = int'($urandom_range(255)) - 128;
      end
  endtask

  task automatic beat(input bit last_b);
    check("in_ready_accum", longint'(obs_ready()), 1);
    vld = 1'b1;
    lst = last_b;
    model_beat();
    @(posedge clk); #1;
    vld = 1'b0;
    lst = 1'b0;
  endtask

  // Entered #1 after the edge that accepted the last beat.
  task automatic wait_result(input string tag, input int stall);
    int k;
    k = 0;
    while (!obs_ovalid() && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) check({tag, "_drain_in_ready"}, longint'(obs_ready()), 0);
    end
    check({tag, "_latency"}, k, cur_depth() + 3);
    for (int i = 0; i < cur_n(); i++)
      for (int j = 0; j < cur_n(); j++)
        check($sformatf("%s_res%0d%0d", tag, i, j), obs_res(i, j), exp_acc[i][j]);
    check({tag, "_ovf"}, longint'(obs_ovf()), longint'(exp_ovf));
    for (int s = 0; s < stall; s++) begin
      fill_rand();
      vld = 1'b1;
      lst = 1'b1;
      @(posedge clk); #1;
      vld = 1'b0;
      lst = 1'b0;
      check({tag, "_stall_ovalid"}, longint'(obs_ovalid()), 1);
      check({tag, "_stall_in_ready"}, longint'(obs_ready()), 0);
      for (int i = 0; i < cur_n(); i++)
        for (int j = 0; j < cur_n(); j++)
          check($sformatf("%s_stall_res%0d%0d", tag, i, j), obs_res(i, j), exp_acc[i][j]);
      check({tag, "_stall_ovf"}, longint'(obs_ovf()), longint'(exp_ovf));
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    check({tag, "_post_ovalid"}, longint'(obs_ovalid()), 0);
    check({tag, "_post_in_ready"}, longint'(obs_ready()), 1);
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb, seen;
    resetn = 1'b0; vld = 1'b0; lst = 1'b0; ordy = 1'b0; sel = 0;
    fill(0, 0, 0);
    model_clear();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    for (int s = 0; s < 2; s++) begin
      sel = s;
      check("rst_in_ready", longint'(obs_ready()), 1);
      check("rst_ovalid", longint'(obs_ovalid()), 0);
      check("rst_ovf", longint'(obs_ovf()), 0);
      for (int i = 0; i < cur_n(); i++)
        for (int j = 0; j < cur_n(); j++) check("rst_res", obs_res(i, j), 0);
    end

    sel = 0;
    fill(1, 0, 0);
    mb[0][0] = 1; mb[0][1] = 2; mb[1][0] = 3; mb[1][1] = 4;
    beat(1'b1);
    wait_result("ident", 0);

    fill(1, 1, 2);
    beat(1'b0);
    beat(1'b1);
    wait_result("b2b", 0);

    sel = 1;
    fill(1, 1, 1);
    beat(1'b1);
    wait_result("n3", 0);

    sel = 0;
    fill_rand();
    beat(1'b1);
    wait_result("stall", 5);
    fill(1, 0, 3);
    beat(1'b1);
    wait_result("after_stall", 0);

    fill(-128, -128, -128);
    for (int b = 0; b < 16; b++) beat(b == 15);
    wait_result("sat", 0);

    fill(7, 2, 9);
    beat(1'b1);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    model_clear();
    check("rst_drain_in_ready", longint'(obs_ready()), 1);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (obs_ovalid()) seen++;
      @(posedge clk); #1;
    end
    check("rst_drain_no_ovalid", seen, 0);
    fill(1, 0, 5);
    beat(1'b1);
    wait_result("post_rst", 0);

    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int t = 0; t < 6; t++) begin
        nb = int'($urandom_range(1, 4));
        for (int b = 0; b < nb; b++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          fill_rand();
          beat(b == nb - 1);
        end
        wait_result($sformatf("rnd%0d_%0d", s, t), int'($urandom_range(0, 3)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
